picorv32_axil_master: RTL and testbench
=======================================

# picorv32_axil_master

Synthesizable AXI4-lite initiator translating the PicoRV32 native memory interface (valid/ready, address, write data, byte strobes) into single AXI4-lite read or write transactions. It sits between the core's native port and any AXI4-lite responder, such as the testbench memory model or an on-fabric memory. It handles one outstanding transaction at a time, accepts AW and W independently, and supports an optional response-timeout watchdog for bring-up on the FPGA.

## Interface
Parameters:
- TIMEOUT_CYCLES, 0: wait-state cycle limit per transaction; 0 disables the watchdog.

Ports:
- sys_clk  in  1  clock; all logic on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- mem_valid  in  1  native request valid; held until mem_ready.
- mem_instr  in  1  request is an instruction fetch.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte strobes; 4'b0000 = read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data; valid when mem_ready=1.
- mem_err  out  1  completion was a timeout; valid with mem_ready.
- timeout_flag  out  1  sticky; set on any timeout, cleared only by reset.
- mem_axi_awvalid/awready  out/in  1  write address handshake.
- mem_axi_awaddr  out  32 and mem_axi_awprot  out  3.
- mem_axi_wvalid/wready  out/in  1  write data handshake.
- mem_axi_wdata  out  32 and mem_axi_wstrb  out  4.
- mem_axi_bvalid/bready  in/out  1  write response handshake.
- mem_axi_arvalid/arready  out/in  1  read address handshake.
- mem_axi_araddr  out  32 and mem_axi_arprot  out  3.
- mem_axi_rvalid/rready  in/out  1  read data handshake.
- mem_axi_rdata  in  32  read data.

## Operation
- Every output is a register. Reset values: all valids and readies 0, mem_ready 0, mem_err 0, timeout_flag 0, all address/data/strb/prot outputs 0.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
- IDLE: when mem_valid=1, latch addr/wdata/wstrb/instr. If wstrb≠0, go to WR_REQ and set awvalid=wvalid=1. Otherwise go to RD_REQ and set arvalid=1.
- Prot: awprot = 3'b000. arprot = {mem_instr,2'b00}, so fetches use 3'b100.
- WR_REQ: awvalid drops on the cycle after its awvalid&awready edge. wvalid drops likewise on its own handshake, independently of awvalid. When both channels are accepted (same or different edges), go to WR_RESP with bready=1.
- WR_RESP: on bvalid&bready, clear bready and go to DONE.
- RD_REQ: on arvalid&arready, clear arvalid, set rready=1 and go to RD_DATA.
- RD_DATA: on rvalid&rready, capture rdata into mem_rdata, clear rready and go to DONE.
- DONE: mem_ready=1 for exactly one cycle, then return to IDLE. mem_rdata holds its value until the next read completes; writes leave it unchanged.
- A mem_valid drop mid-transaction is ignored; the AXI transaction runs to completion.
- Watchdog (TIMEOUT_CYCLES>0):
  - A wait counter clears on leaving IDLE and increments each cycle spent in WR_REQ, WR_RESP, RD_REQ or RD_DATA.
  - When the counter reaches TIMEOUT_CYCLES, all AXI valids and readies drop, the state goes to DONE with mem_err=1, mem_rdata=32'h0, and timeout_flag is set.
  - The counter is ceil(log2(TIMEOUT_CYCLES+1)) bits wide and saturates; it never wraps.
- resetn=0 in any state: immediate return to IDLE with the reset values above. The in-flight transaction is abandoned; the responder must be reset with it.

## Timing
- Acceptance: IDLE with mem_valid=1 at edge N. The AXI valid is high during cycle N+1.
- Minimum latency, acceptance to mem_ready high: 3 cycles. This applies to reads and writes when the responder accepts in the first valid cycle and returns its response in the next.
- Each responder wait cycle on any channel adds exactly one cycle.
- Back-to-back: IDLE accepts a new request in the cycle after DONE. The minimum request period is therefore 4 cycles.
- A valid never drops before its handshake except on timeout or reset.
- AXI outputs are stable while valid=1 and the ready is low.

## Test plan
- Read 0x0000_0100, instr=1, responder rdata 0x1234_5678 with zero waits -> arprot=3'b100; mem_ready 3 cycles after acceptance; mem_rdata=0x1234_5678; mem_err=0.
- Write 0x2000_0000, data 123456789, strb 4'hF; awready 1 cycle late, wready 3 cycles late -> awvalid drops alone first; bready rises only after both are accepted; mem_ready once.
- Write with strb 4'b0101, wready before awready -> wvalid drops first; wstrb=4'b0101 on the bus; exactly one AW, one W and one B handshake.
- TIMEOUT_CYCLES=16, responder never asserts rvalid -> mem_ready with mem_err=1 and rdata 0 after 16 wait cycles; timeout_flag=1 until reset; a following read completes normally.
- Back-to-back read/write/read with random responder delays (0–5) -> transactions in request order; exactly one mem_ready per request; data matches a memory model.
- resetn=0 asserted in WR_RESP -> next cycle: all outputs at reset values, state IDLE; timeout_flag cleared.

Source files
------------

// File: rtl/picorv32_axil_master.sv
// PicoRV32 native memory port to AXI4-lite initiator: one transaction in flight,
// AW/W accepted independently, optional wait-state watchdog.
module picorv32_axil_master #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        sys_clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic        timeout_flag,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] wait_cnt, wait_cnt_n, wait_inc;
  logic          in_wait, tmo_hit;

  logic        awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
  logic        mem_ready_n, mem_err_n, timeout_flag_n;
  logic [31:0] awaddr_n, wdata_n, araddr_n, mem_rdata_n;
  logic [3:0]  wstrb_n;
  logic [2:0]  arprot_n;

  assign in_wait  = (state == WR_REQ) || (state == WR_RESP) ||
                    (state == RD_REQ) || (state == RD_DATA);
  assign wait_inc = (wait_cnt == {CW{1'b1}}) ? wait_cnt : wait_cnt + CW'(1);
  assign tmo_hit  = (TIMEOUT_CYCLES > 0) && in_wait && (wait_inc == TMO);

  always_comb begin
    state_n        = state;
    awvalid_n      = mem_axi_awvalid;
    wvalid_n       = mem_axi_wvalid;
    bready_n       = mem_axi_bready;
    arvalid_n      = mem_axi_arvalid;
    rready_n       = mem_axi_rready;
    awaddr_n       = mem_axi_awaddr;
    wdata_n        = mem_axi_wdata;
    wstrb_n        = mem_axi_wstrb;
    araddr_n       = mem_axi_araddr;
    arprot_n       = mem_axi_arprot;
    mem_rdata_n    = mem_rdata;
    mem_ready_n    = 1'b0;
    mem_err_n      = 1'b0;
    timeout_flag_n = timeout_flag;
    wait_cnt_n     = (state == IDLE) ? '0 : (in_wait ? wait_inc : wait_cnt);

    case (state)
      IDLE: if (mem_valid) begin
        if (mem_wstrb != 4'b0000) begin
          state_n   = WR_REQ;
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
          awaddr_n  = mem_addr;
          wdata_n   = mem_wdata;
          wstrb_n   = mem_wstrb;
        end else begin
          state_n   = RD_REQ;
          arvalid_n = 1'b1;
          araddr_n  = mem_addr;
          arprot_n  = {mem_instr, 2'b00};
        end
      end
      WR_REQ: begin
        // A channel already accepted has its valid low; each drops on its own handshake.
        if (mem_axi_awready) awvalid_n = 1'b0;
        if (mem_axi_wready)  wvalid_n  = 1'b0;
        if ((!mem_axi_awvalid || mem_axi_awready) && (!mem_axi_wvalid || mem_axi_wready)) begin
          state_n  = WR_RESP;
          bready_n = 1'b1;
        end
      end
      WR_RESP: if (mem_axi_bvalid) begin
        bready_n    = 1'b0;
        state_n     = DONE;
        mem_ready_n = 1'b1;
      end
      RD_REQ: if (mem_axi_arready) begin
        arvalid_n = 1'b0;
        rready_n  = 1'b1;
        state_n   = RD_DATA;
      end
      RD_DATA: if (mem_axi_rvalid) begin
        mem_rdata_n = mem_axi_rdata;
        rready_n    = 1'b0;
        state_n     = DONE;
        mem_ready_n = 1'b1;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // A response landing on the limit cycle still completes normally.
    if (tmo_hit && state_n != DONE) begin
      state_n        = DONE;
      awvalid_n      = 1'b0;
      wvalid_n       = 1'b0;
      bready_n       = 1'b0;
      arvalid_n      = 1'b0;
      rready_n       = 1'b0;
      mem_ready_n    = 1'b1;
      mem_err_n      = 1'b1;
      mem_rdata_n    = 32'h0;
      timeout_flag_n = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      mem_axi_awvalid <= 1'b0;
      mem_axi_wvalid  <= 1'b0;
      mem_axi_bready  <= 1'b0;
      mem_axi_arvalid <= 1'b0;
      mem_axi_rready  <= 1'b0;
      mem_axi_awaddr  <= '0;
      mem_axi_awprot  <= '0;
      mem_axi_wdata   <= '0;
      mem_axi_wstrb   <= '0;
      mem_axi_araddr  <= '0;
      mem_axi_arprot  <= '0;
      mem_rdata       <= '0;
      mem_ready       <= 1'b0;
      mem_err         <= 1'b0;
      timeout_flag    <= 1'b0;
    end else begin
      state           <= state_n;
      wait_cnt        <= wait_cnt_n;
      mem_axi_awvalid <= awvalid_n;
      mem_axi_wvalid  <= wvalid_n;
      mem_axi_bready  <= bready_n;
      mem_axi_arvalid <= arvalid_n;
      mem_axi_rready  <= rready_n;
      mem_axi_awaddr  <= awaddr_n;
      mem_axi_awprot  <= 3'b000;
      mem_axi_wdata   <= wdata_n;
      mem_axi_wstrb   <= wstrb_n;
      mem_axi_araddr  <= araddr_n;
      mem_axi_arprot  <= arprot_n;
      mem_rdata       <= mem_rdata_n;
      mem_ready       <= mem_ready_n;
      mem_err         <= mem_err_n;
      timeout_flag    <= timeout_flag_n;
    end
  end

endmodule

// File: tb/tb_picorv32_axil_master.sv
// Bench for picorv32_axil_master: delay-programmable AXI4-lite responder, reference
// memory scoreboard, vector table plus directed timeout/back-to-back/reset sequences.
module tb_picorv32_axil_master;

  logic        sys_clk = 1'b0;
  logic        resetn  = 1'b0;
  logic        mem_valid = 1'b0, mem_instr = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready, mem_err, timeout_flag;
  logic [31:0] mem_rdata;
  logic        mem_axi_awvalid, mem_axi_awready, mem_axi_wvalid, mem_axi_wready;
  logic        mem_axi_bvalid, mem_axi_bready, mem_axi_arvalid, mem_axi_arready;
  logic        mem_axi_rvalid, mem_axi_rready;
  logic [31:0] mem_axi_awaddr, mem_axi_wdata, mem_axi_araddr, mem_axi_rdata;
  logic [2:0]  mem_axi_awprot, mem_axi_arprot;
  logic [3:0]  mem_axi_wstrb;

  always #5 sys_clk = ~sys_clk;

  picorv32_axil_master #(.TIMEOUT_CYCLES(16)) dut (
    .sys_clk(sys_clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_err(mem_err), .timeout_flag(timeout_flag),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
    .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
    .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
    .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
    .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
    .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
    .mem_axi_rdata(mem_axi_rdata)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- memory contents shared by responder and reference model
  logic [31:0] rmem   [logic [31:0]];
  logic [31:0] refmem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] st);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [31:0] k = a & ~32'h3;
    return refmem.exists(k) ? refmem[k] : init_word(k);
  endfunction

  // ---------------- AXI4-lite responder, all decisions at negedge
  int  aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  bit  r_never = 0, flush = 0;
  int  aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
  logic [3:0]  cap_wstrb = '0;
  logic [2:0]  cap_awprot = '0, cap_arprot = '0;

  initial begin
    int  aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit  aw_got, w_got, wr_pend, rd_pend, b_fire, r_fire;
    logic [31:0] k;
    mem_axi_awready = 0; mem_axi_wready = 0; mem_axi_bvalid = 0;
    mem_axi_arready = 0; mem_axi_rvalid = 0; mem_axi_rdata = '0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    {aw_got, w_got, wr_pend, rd_pend, b_fire, r_fire} = '0;
    forever begin
      @(negedge sys_clk);
      if (!resetn || flush) begin
        mem_axi_awready = 0; mem_axi_wready = 0; mem_axi_bvalid = 0;
        mem_axi_arready = 0; mem_axi_rvalid = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        {aw_got, w_got, wr_pend, rd_pend, b_fire, r_fire} = '0;
        flush = 0;
      end else begin
        if (mem_axi_awready) begin mem_axi_awready = 0; aw_hs++; aw_got = 1; end
        else if (mem_axi_awvalid) begin
          if (aw_cnt >= aw_dly) begin
            mem_axi_awready = 1; cap_awaddr = mem_axi_awaddr; cap_awprot = mem_axi_awprot; aw_cnt = 0;
          end else aw_cnt++;
        end
        if (mem_axi_wready) begin mem_axi_wready = 0; w_hs++; w_got = 1; end
        else if (mem_axi_wvalid) begin
          if (w_cnt >= w_dly) begin
            mem_axi_wready = 1; cap_wdata = mem_axi_wdata; cap_wstrb = mem_axi_wstrb; w_cnt = 0;
          end else w_cnt++;
        end
        if (aw_got && w_got) begin aw_got = 0; w_got = 0; wr_pend = 1; b_cnt = 0; end
        if (b_fire) begin mem_axi_bvalid = 0; b_fire = 0; b_hs++; end
        else begin
          if (!mem_axi_bvalid && wr_pend) begin
            if (b_cnt >= b_dly) begin
              k = cap_awaddr & ~32'h3;
              rmem[k] = merge(rmem.exists(k) ? rmem[k] : init_word(k), cap_wdata, cap_wstrb);
              mem_axi_bvalid = 1; wr_pend = 0;
            end else b_cnt++;
          end
          if (mem_axi_bvalid && mem_axi_bready) b_fire = 1;
        end
        if (mem_axi_arready) begin mem_axi_arready = 0; ar_hs++; rd_pend = 1; r_cnt = 0; end
        else if (mem_axi_arvalid) begin
          if (ar_cnt >= ar_dly) begin
            mem_axi_arready = 1; cap_araddr = mem_axi_araddr; cap_arprot = mem_axi_arprot; ar_cnt = 0;
          end else ar_cnt++;
        end
        if (r_fire) begin mem_axi_rvalid = 0; r_fire = 0; r_hs++; end
        else begin
          if (!mem_axi_rvalid && rd_pend && !r_never) begin
            if (r_cnt >= r_dly) begin
              k = cap_araddr & ~32'h3;
              mem_axi_rdata  = rmem.exists(k) ? rmem[k] : init_word(k);
              mem_axi_rvalid = 1; rd_pend = 0;
            end else r_cnt++;
          end
          if (mem_axi_rvalid && mem_axi_rready) r_fire = 1;
        end
      end
    end
  end

  // ---------------- scoreboard: expectation pushed at drive, popped on mem_ready
  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  exp_t        sbq[$];
  logic [31:0] last_rd = '0;

  initial forever begin
    exp_t e;
    @(negedge sys_clk);
    if (resetn && mem_ready) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_mem_ready actual=1 required=0");
      end else begin
        e = sbq.pop_front();
        chk("mem_rdata", mem_rdata, e.rdata);
        chk("mem_err", mem_err, e.err);
      end
    end
  end

  bit f_aw_first, f_w_first, f_b_early;

  task automatic set_dly(input int a, input int w, input int b, input int ar, input int r);
    aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  // Called at a negedge; returns at the negedge where mem_ready is seen.
  task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                        input logic ins, input bit tmo, input int exp_lat, input string nm);
    exp_t e;
    int   lat = 0;
    if (tmo) begin e.rdata = 32'h0; e.err = 1'b1; last_rd = 32'h0; end
    else if (st != 4'b0) begin
      refmem[a & ~32'h3] = merge(ref_rd(a), wd, st);
      e.rdata = last_rd; e.err = 1'b0;
    end else begin e.rdata = ref_rd(a); e.err = 1'b0; last_rd = e.rdata; end
    sbq.push_back(e);
    {f_aw_first, f_w_first, f_b_early} = '0;
    mem_valid = 1; mem_addr = a; mem_wdata = wd; mem_wstrb = st; mem_instr = ins;
    do begin
      @(negedge sys_clk);
      lat++;
      if (!mem_axi_awvalid && mem_axi_wvalid) f_aw_first = 1;
      if (mem_axi_awvalid && !mem_axi_wvalid) f_w_first = 1;
      if (mem_axi_bready && (mem_axi_awvalid || mem_axi_wvalid)) f_b_early = 1;
    end while (!mem_ready && lat < 100);
    mem_valid = 0; mem_wstrb = '0; mem_instr = 0;
    chk({nm, "_latency"}, lat, exp_lat);
  endtask

  typedef struct {
    logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; logic instr;
    int d_a; int d_w; int d_b; int lat; logic [2:0] prot;
  } vec_t;

  initial begin
    vec_t vt[7];
    int   h[5];
    bit   wr;
    int   n;
    logic [145:0] outs;

    rmem[32'h100] = 32'h1234_5678; refmem[32'h100] = 32'h1234_5678;
    // read: d_a=ar wait, d_b=r wait; write: d_a=aw, d_w=w, d_b=b waits
    vt[0] = '{32'h0000_0100, 32'h0,         4'h0,    1'b1, 0, 0, 0, 3, 3'b100};
    vt[1] = '{32'h2000_0000, 32'd123456789, 4'hF,    1'b0, 1, 3, 0, 6, 3'b000};
    vt[2] = '{32'h2000_0000, 32'h0,         4'h0,    1'b0, 0, 0, 0, 3, 3'b000};
    vt[3] = '{32'h2000_0004, 32'hDEAD_BEEF, 4'b0101, 1'b0, 2, 0, 1, 6, 3'b000};
    vt[4] = '{32'h2000_0004, 32'h0,         4'h0,    1'b0, 2, 0, 3, 8, 3'b000};
    vt[5] = '{32'h0000_0300, 32'hA1B2_C3D4, 4'b1000, 1'b1, 0, 0, 4, 7, 3'b000};
    vt[6] = '{32'h0000_0300, 32'h0,         4'h0,    1'b1, 0, 0, 1, 4, 3'b100};

    repeat (3) @(negedge sys_clk);
    outs = {mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot, mem_axi_wvalid, mem_axi_wdata,
            mem_axi_wstrb, mem_axi_bready, mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
            mem_axi_rready, mem_ready, mem_rdata, mem_err, timeout_flag};
    chk("reset_outputs", outs, '0);
    resetn = 1;
    @(negedge sys_clk);

    foreach (vt[i]) begin
      wr = (vt[i].strb != 4'b0);
      if (wr) set_dly(vt[i].d_a, vt[i].d_w, vt[i].d_b, 0, 0);
      else    set_dly(0, 0, 0, vt[i].d_a, vt[i].d_b);
      @(negedge sys_clk);
      h = '{aw_hs, w_hs, b_hs, ar_hs, r_hs};
      do_req(vt[i].addr, vt[i].wdata, vt[i].strb, vt[i].instr, 1'b0, vt[i].lat, $sformatf("vec%0d", i));
      @(negedge sys_clk);
      chk($sformatf("vec%0d_handshakes", i),
          {8'(aw_hs - h[0]), 8'(w_hs - h[1]), 8'(b_hs - h[2]), 8'(ar_hs - h[3]), 8'(r_hs - h[4])},
          wr ? 40'h01_01_01_00_00 : 40'h00_00_00_01_01);
      if (wr) begin
        chk($sformatf("vec%0d_aw_w_bus", i), {cap_awaddr, cap_awprot, cap_wdata, cap_wstrb},
            {vt[i].addr, vt[i].prot, vt[i].wdata, vt[i].strb});
        chk($sformatf("vec%0d_order", i), {f_aw_first, f_w_first, f_b_early},
            {vt[i].d_a < vt[i].d_w, vt[i].d_w < vt[i].d_a, 1'b0});
      end else
        chk($sformatf("vec%0d_ar_bus", i), {cap_araddr, cap_arprot}, {vt[i].addr, vt[i].prot});
    end

    // Responder never returns read data: watchdog completes with an error.
    set_dly(0, 0, 0, 0, 0); r_never = 1;
    @(negedge sys_clk);
    do_req(32'h0000_0040, 32'h0, 4'h0, 1'b0, 1'b1, 17, "timeout");
    chk("timeout_flag_set", timeout_flag, 1'b1);
    r_never = 0; flush = 1;
    repeat (2) @(negedge sys_clk);
    do_req(32'h0000_0100, 32'h0, 4'h0, 1'b0, 1'b0, 3, "after_timeout");
    @(negedge sys_clk);
    chk("timeout_flag_sticky", timeout_flag, 1'b1);

    // Back-to-back read/write/read; the next request waits out the DONE cycle.
    @(negedge sys_clk);
    for (int i = 0; i < 9; i++) begin
      int a = $urandom_range(0, 5), w = $urandom_range(0, 5), b = $urandom_range(0, 5);
      int ar = $urandom_range(0, 5), r = $urandom_range(0, 5);
      logic [31:0] ad = 32'h200 + 32'(4 * $urandom_range(0, 1));
      set_dly(a, w, b, ar, r);
      if (i % 3 == 1)
        do_req(ad, $urandom, 4'($urandom_range(1, 15)), 1'b0, 1'b0,
               (i > 0 ? 1 : 0) + 3 + (a > w ? a : w) + b, $sformatf("b2b%0d", i));
      else
        do_req(ad, 32'h0, 4'h0, 1'($urandom_range(0, 1)), 1'b0,
               (i > 0 ? 1 : 0) + 3 + ar + r, $sformatf("b2b%0d", i));
    end
    repeat (2) @(negedge sys_clk);

    // Reset while waiting for the write response.
    set_dly(0, 0, 5, 0, 0);
    mem_valid = 1; mem_addr = 32'h2000_0000; mem_wdata = 32'hFFFF_FFFF; mem_wstrb = 4'hF;
    n = 0;
    do begin @(negedge sys_clk); n++; end while (!mem_axi_bready && n < 20);
    chk("reached_wr_resp", mem_axi_bready, 1'b1);
    resetn = 0; mem_valid = 0; mem_wstrb = '0;
    @(posedge sys_clk); #1;
    outs = {mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot, mem_axi_wvalid, mem_axi_wdata,
            mem_axi_wstrb, mem_axi_bready, mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
            mem_axi_rready, mem_ready, mem_rdata, mem_err, timeout_flag};
    chk("reset_in_wr_resp_outputs", outs, '0);
    repeat (2) @(negedge sys_clk);
    resetn = 1; last_rd = '0;
    chk("pending_at_reset", sbq.size(), 0);
    sbq.delete();
    @(negedge sys_clk);
    set_dly(0, 0, 0, 0, 0);
    do_req(32'h2000_0000, 32'h0, 4'h0, 1'b0, 1'b0, 3, "after_reset");
    repeat (2) @(negedge sys_clk);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
